dds_phase_reader: RTL and testbench

DDS_PHASE_READER -- requirements
Module: dds_phase_reader

---
 rtl/dds_pkg.sv | 14 +
 rtl/dds_tick_gen.sv | 29 ++
 rtl/dds_phase_reader.sv | 108 ++++++++++
 tb/tb_dds_phase_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths and FSM state encoding for the DDS phase reader.
package dds_pkg;

   localparam int unsigned ACC_WIDTH_DEF  = 24;
   localparam int unsigned ADDR_WIDTH_DEF = 9;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned DIV_WIDTH_DEF  = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } dds_state_t;

endpackage

// File: rtl/dds_tick_gen.sv
// Sample-rate prescaler: counts 0..div while running and flags the last count.
module dds_tick_gen
   import dds_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] count;

   assign tick = run && (count == div);

   // Count up to div and roll over; held at zero whenever not running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!run || (count == div)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dds_phase_reader.sv
// DDS phase accumulator driving an external registered wavetable RAM,
// with a one-entry tuning-word buffer and a sample/wrap strobe pipeline.
module dds_phase_reader
   import dds_pkg::*;
#(
   parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIV_WIDTH-1:0]  div,
   input  logic [ACC_WIDTH-1:0]  tw_data,
   input  logic                  tw_valid,
   output logic                  tw_ready,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] sample,
   output logic                  sample_valid,
   output logic                  wrap
);

   dds_state_t           state;
   logic                 run;
   logic                 tick;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] tw;
   logic [ACC_WIDTH-1:0] pend_word;
   logic                 pending;
   logic [ACC_WIDTH-1:0] tw_eff;
   logic [ACC_WIDTH:0]   sum;
   logic [1:0]           v_pipe;
   logic [1:0]           w_pipe;

   assign run      = (state == ST_RUN);
   assign tw_ready = ~pending;
   // A word still pending at a tick is folded into that tick's addition.
   assign tw_eff   = pending ? pend_word : tw;
   assign sum      = {1'b0, acc} + {1'b0, tw_eff};
   assign rd_addr  = acc[ACC_WIDTH-1 -: ADDR_WIDTH];

   dds_tick_gen #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_tick_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (run),
      .div  (div),
      .tick (tick)
   );

   // Run/idle state follows the sampled enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= en ? ST_RUN : ST_IDLE;
      end
   end

   // Phase accumulate on tick; tuning word commits on tick, or at once when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         tw  <= '0;
      end else if (tick) begin
         acc <= sum[ACC_WIDTH-1:0];
         tw  <= tw_eff;
      end else if ((state == ST_IDLE) && pending) begin
         tw <= pend_word;
      end
   end

   // One-entry tuning-word buffer; accepts only while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         pend_word <= '0;
      end else if (tw_valid && !pending) begin
         pending   <= 1'b1;
         pend_word <= tw_data;
      end else if (tick || (state == ST_IDLE)) begin
         pending <= 1'b0;
      end
   end

   // Strobe/wrap shift covering the RAM read latency; runs regardless of state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_pipe       <= '0;
         w_pipe       <= '0;
         sample_valid <= 1'b0;
         wrap         <= 1'b0;
         sample       <= '0;
      end else begin
         v_pipe       <= {v_pipe[0], tick};
         w_pipe       <= {w_pipe[0], tick & sum[ACC_WIDTH]};
         sample_valid <= v_pipe[1];
         wrap         <= w_pipe[1];
         if (v_pipe[1]) begin
            sample <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_dds_phase_reader.sv
// Self-checking bench for dds_phase_reader paired with a 512x8 wavetable
// holding mem[i] = i[7:0].
module tb_dds_phase_reader;

   localparam int ACC  = 24;
   localparam int ADDR = 9;
   localparam int DATA = 8;
   localparam int DIVW = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic [DIVW-1:0] div = '0;
   logic [ACC-1:0]  tw_data = '0;
   logic            tw_valid = 1'b0;
   logic            tw_ready;
   logic [ADDR-1:0] rd_addr;
   logic [DATA-1:0] rd_data;
   logic [DATA-1:0] sample;
   logic            sample_valid;
   logic            wrap;

   always #5 clk = ~clk;

   dds_phase_reader #(
      .ACC_WIDTH (ACC),
      .ADDR_WIDTH(ADDR),
      .DATA_WIDTH(DATA),
      .DIV_WIDTH (DIVW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .div         (div),
      .tw_data     (tw_data),
      .tw_valid    (tw_valid),
      .tw_ready    (tw_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .sample      (sample),
      .sample_valid(sample_valid),
      .wrap        (wrap)
   );

   // Wavetable RAM with registered output
   logic [7:0] mem [0:511];
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'(i);
      rd_data = '0;
      forever begin
         @(posedge clk);
         rd_data <= mem[rd_addr];
      end
   end

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event, expected one within bound at %0t", name, $time);
   endtask

   // Reference model: phase arithmetic per tick, outputs delivered from a
   // queue of samples due a fixed number of edges later.
   typedef struct {
      int         due;
      logic [7:0] d;
      logic       w;
   } ev_t;
   ev_t            q[$];
   int             cyc = 0;
   logic           m_run, m_pend, m_sv, m_wrap, m_t, m_x;
   logic [15:0]    m_cnt;
   logic [ACC-1:0] m_acc, m_tw, m_pw, m_eff;
   logic [ACC:0]   m_s;
   logic [7:0]     m_sample;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_run = 0; m_pend = 0; m_sv = 0; m_wrap = 0; m_cnt = '0;
            m_acc = '0; m_tw = '0; m_pw = '0; m_sample = '0;
            q.delete();
         end else begin
            cyc++;
            m_sv   = 1'b0;
            m_wrap = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
               m_sv     = 1'b1;
               m_sample = q[0].d;
               m_wrap   = q[0].w;
               void'(q.pop_front());
            end
            m_t   = m_run && (m_cnt == div);
            m_x   = tw_valid && !m_pend;
            m_eff = m_pend ? m_pw : m_tw;
            if (m_t) begin
               m_s   = {1'b0, m_acc} + {1'b0, m_eff};
               m_acc = m_s[ACC-1:0];
               m_tw  = m_eff;
               m_pend = 1'b0;
               q.push_back('{cyc + 2, m_s[22:15], m_s[ACC]});
            end else if (!m_run && m_pend) begin
               m_tw   = m_pw;
               m_pend = 1'b0;
            end
            if (m_x) begin
               m_pend = 1'b1;
               m_pw   = tw_data;
            end
            if (!m_run || m_cnt == div) m_cnt = '0;
            else m_cnt = m_cnt + 16'd1;
            m_run = en;
         end
      end
   end

   // Continuous comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on && rst_n) begin
            check("rd_addr", rd_addr, m_acc[ACC-1 -: ADDR]);
            check("sample_valid", sample_valid, m_sv);
            check("wrap", wrap, m_wrap);
            check("sample", sample, m_sample);
            check("tw_ready", tw_ready, !m_pend);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut();
      en       = 1'b0;
      tw_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic load(input logic [ACC-1:0] w, input logic [DIVW-1:0] d);
      reset_dut();
      tw_data  = w;
      tw_valid = 1'b1;
      step();
      tw_valid = 1'b0;
      div      = d;
      step();
      en = 1'b1;
   endtask

   task automatic wait_strobe(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         step();
         n++;
         if (sample_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_addr_change(output int n, output bit ok);
      logic [ADDR-1:0] prev;
      prev = rd_addr;
      n    = 0;
      ok   = 1'b0;
      while (!ok && n < 200) begin
         step();
         n++;
         if (rd_addr != prev) ok = 1'b1;
      end
   endtask

   typedef struct packed {
      logic [23:0]     tw;
      logic [15:0]     dv;
      logic [3:0][8:0] addr;
      logic [3:0]      w;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int              n;
      bit              ok;
      logic [ADDR-1:0] a0;

      vecs[0] = '{tw: 24'h008000, dv: 16'd3, addr: {9'd4,   9'd3,   9'd2,   9'd1},   w: 4'b0000};
      vecs[1] = '{tw: 24'h400000, dv: 16'd0, addr: {9'd0,   9'd384, 9'd256, 9'd128}, w: 4'b1000};
      vecs[2] = '{tw: 24'h000000, dv: 16'd1, addr: {9'd0,   9'd0,   9'd0,   9'd0},   w: 4'b0000};
      vecs[3] = '{tw: 24'hC00000, dv: 16'd2, addr: {9'd0,   9'd128, 9'd256, 9'd384}, w: 4'b1110};

      reset_dut();
      chk_on = 1'b1;
      step();
      check("rst_rd_addr", rd_addr, 0);
      check("rst_sample", sample, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_wrap", wrap, 0);
      check("rst_tw_ready", tw_ready, 1);

      // Table-driven runs: expected sample sequence, wrap tags and strobe spacing
      for (int i = 0; i < 4; i++) begin
         load(vecs[i].tw, vecs[i].dv);
         for (int k = 0; k < 4; k++) begin
            wait_strobe(n, ok);
            if (!ok) begin
               timeout("vec_strobe");
            end else begin
               check("vec_sample", sample, 32'(vecs[i].addr[k][7:0]));
               check("vec_wrap", wrap, vecs[i].w[k]);
               if (k > 0) check("vec_spacing", n, 32'(vecs[i].dv) + 1);
            end
         end
         en = 1'b0;
         step();
      end

      // Handshake: pending word used by next tick, second offer stalls
      load(24'h000000, 16'd7);
      repeat (3) step();
      tw_data  = 24'h010000;
      tw_valid = 1'b1;
      step();
      check("hs_ready_low", tw_ready, 0);
      tw_data = 24'h020000;
      wait_addr_change(n, ok);
      if (!ok) timeout("hs_tick1");
      check("hs_first_add", rd_addr, 2);
      check("hs_ready_back", tw_ready, 1);
      step();
      check("hs_second_taken", tw_ready, 0);
      tw_valid = 1'b0;
      wait_addr_change(n, ok);
      if (!ok) timeout("hs_tick2");
      check("hs_second_add", rd_addr, 6);

      // Offer coincident with a tick: old word now, new word next tick
      load(24'h008000, 16'd0);
      repeat (3) step();
      a0       = rd_addr;
      tw_data  = 24'h100000;
      tw_valid = 1'b1;
      step();
      check("sim_old_word", rd_addr, 32'(a0 + 9'd1));
      tw_valid = 1'b0;
      step();
      check("sim_new_word", rd_addr, 32'(a0 + 9'd33));

      // Enable drop: coincident tick executes, in-flight samples drain, acc frozen
      load(24'h008000, 16'd0);
      repeat (4) step();
      a0 = rd_addr;
      en = 1'b0;
      step();
      check("endrop_coincident", rd_addr, 32'(a0 + 9'd1));
      step();
      check("endrop_sv1", sample_valid, 1);
      check("endrop_s1", sample, 32'(a0[7:0]));
      step();
      check("endrop_sv2", sample_valid, 1);
      check("endrop_s2", sample, 32'(a0[7:0] + 8'd1));
      div = 16'd3;
      step();
      check("endrop_sv_end", sample_valid, 0);
      check("endrop_frozen", rd_addr, 32'(a0 + 9'd1));
      en = 1'b1;
      wait_addr_change(n, ok);
      if (!ok) timeout("reen_tick");
      check("reen_latency", n, 5);

      // Reset between a tick and its strobe, with a word pending
      load(24'h008000, 16'd3);
      wait_strobe(n, ok);
      if (!ok) timeout("rst_mid_strobe");
      step();
      tw_data  = 24'h040000;
      tw_valid = 1'b1;
      step();
      tw_valid = 1'b0;
      check("rst_mid_pending", tw_ready, 0);
      rst_n = 1'b0;
      #1;
      check("rstm_rd_addr", rd_addr, 0);
      check("rstm_sample", sample, 0);
      check("rstm_sv", sample_valid, 0);
      check("rstm_wrap", wrap, 0);
      check("rstm_tw_ready", tw_ready, 1);
      step();
      rst_n = 1'b1;
      repeat (3) begin
         step();
         check("rstm_no_strobe", sample_valid, 0);
      end
      wait_strobe(n, ok);
      if (!ok) timeout("rstm_restart");
      check("rstm_tw_zero_addr", rd_addr, 0);
      check("rstm_tw_zero_sample", sample, 0);
      check("rstm_tw_zero_wrap", wrap, 0);

      // Randomized traffic checked by the reference model
      for (int b = 0; b < 8; b++) begin
         en = 1'b0;
         step();
         step();
         div = 16'($urandom_range(0, 5));
         for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 199) == 0) reset_dut();
            en       = ($urandom_range(0, 15) != 0);
            tw_valid = ($urandom_range(0, 2) == 0);
            tw_data  = 24'($urandom);
            step();
         end
      end
      en       = 1'b0;
      tw_valid = 1'b0;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
